// File: rtl/station_pkg.sv
// Shared types and constants for the line-follower station sequencer.
package station_pkg;

    localparam int unsigned STN_W = 6;
    localparam int unsigned CMD_W = 8;
    localparam int unsigned ID_W  = 8;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] CMD_GO   = 2'b01;
    localparam logic [1:0] CMD_STOP = 2'b00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRANSIT = 2'd1,
        FAULT   = 2'd2
    } state_t;

    // Host command payload as presented on cmd[7:0]
    typedef struct packed {
        logic [1:0]       op;
        logic [STN_W-1:0] stn;
    } cmd_t;

    // Station counter increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/station_wdog.sv
// No-station watchdog: saturating counter, cleared on a station read,
// advanced while the robot is actually moving.
module station_wdog #(
    parameter int unsigned TMO_W = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_c
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Next count: clear dominates, otherwise count up and hold at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the moving cycle that brings the count to all-ones
    assign expired_c = inc_i && !clr_i && (cnt_d == '1);

endmodule

// File: rtl/station_ctrl.sv
// Navigation sequencer: latches a destination from host GO/STOP commands,
// consumes barcode station reads while travelling, and stops on arrival,
// on STOP, or on a no-station watchdog fault.
// Optional build macro OBSTACLE_BUZZ_EN enables the obstacle buzzer divider.
module station_ctrl
    import station_pkg::*;
#(
    parameter int unsigned TMO_W      = 26,
    parameter int unsigned BUZZ_DIV_W = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CMD_W-1:0] cmd,
    input  logic             cmd_rdy,
    output logic             clr_cmd_rdy,
    input  logic [ID_W-1:0]  ID,
    input  logic             ID_vld,
    output logic             clr_ID_vld,
    input  logic             OK2Move,
    output logic             go,
    output logic             in_transit,
    output logic             timeout,
    output logic [CNT_W-1:0] stn_cnt,
    output logic             buzz_en
);

    state_t            state_q;
    logic [STN_W-1:0]  dest_q;
    logic              clr_cmd_q;
    logic              clr_id_q;
    logic              go_q;
    logic              in_transit_q;
    logic              timeout_q;
    logic [CNT_W-1:0]  stn_cnt_q;

    cmd_t              cmd_s;
    logic              take_cmd_c;
    logic              take_id_c;
    logic              is_go_c;
    logic              is_stop_c;
    logic              id_match_c;
    logic              wd_clr_c;
    logic              wd_inc_c;
    logic              wd_expired_c;
    logic              unused_id_hi;

    assign cmd_s = cmd_t'(cmd);

    // A request is new unless we are pulsing its clear right now; the source
    // only drops rdy the cycle after it sees the clear.
    assign take_cmd_c = cmd_rdy && !clr_cmd_q;
    assign take_id_c  = ID_vld && !clr_id_q;
    assign is_go_c    = take_cmd_c && (cmd_s.op == CMD_GO);
    assign is_stop_c  = take_cmd_c && (cmd_s.op == CMD_STOP);
    assign id_match_c = take_id_c && (ID[STN_W-1:0] == dest_q);

    // Only the low station bits of a barcode read are meaningful
    assign unused_id_hi = ^ID[ID_W-1:STN_W];

    // Watchdog restarts on departure and on every station read in transit
    assign wd_clr_c = ((state_q == IDLE) && is_go_c) ||
                      ((state_q == TRANSIT) && take_id_c);
    assign wd_inc_c = (state_q == TRANSIT) && OK2Move;

    station_wdog #(
        .TMO_W (TMO_W)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (wd_clr_c),
        .inc_i     (wd_inc_c),
        .expired_c (wd_expired_c)
    );

    // Sequencer state, handshake pulses and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dest_q       <= '0;
            clr_cmd_q    <= 1'b0;
            clr_id_q     <= 1'b0;
            go_q         <= 1'b0;
            in_transit_q <= 1'b0;
            timeout_q    <= 1'b0;
            stn_cnt_q    <= '0;
        end else begin
            clr_cmd_q <= take_cmd_c;
            clr_id_q  <= take_id_c;
            case (state_q)
                IDLE: begin
                    go_q <= 1'b0;
                    if (is_go_c) begin
                        dest_q       <= cmd_s.stn;
                        stn_cnt_q    <= '0;
                        in_transit_q <= 1'b1;
                        state_q      <= TRANSIT;
                    end
                end
                TRANSIT: begin
                    go_q <= OK2Move;
                    if (take_id_c) begin
                        stn_cnt_q <= sat_inc(stn_cnt_q);
                    end
                    // A command seen with a station read decides the outcome
                    if (is_stop_c) begin
                        in_transit_q <= 1'b0;
                        go_q         <= 1'b0;
                        state_q      <= IDLE;
                    end else if (wd_expired_c) begin
                        timeout_q    <= 1'b1;
                        in_transit_q <= 1'b0;
                        go_q         <= 1'b0;
                        state_q      <= FAULT;
                    end else if (is_go_c) begin
                        dest_q    <= cmd_s.stn;
                        stn_cnt_q <= '0;
                    end else if (id_match_c) begin
                        in_transit_q <= 1'b0;
                        go_q         <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                FAULT: begin
                    go_q <= 1'b0;
                    if (is_stop_c) begin
                        timeout_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    go_q         <= 1'b0;
                    in_transit_q <= 1'b0;
                    timeout_q    <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign clr_cmd_rdy = clr_cmd_q;
    assign clr_ID_vld  = clr_id_q;
    assign go          = go_q;
    assign in_transit  = in_transit_q;
    assign timeout     = timeout_q;
    assign stn_cnt     = stn_cnt_q;

`ifdef OBSTACLE_BUZZ_EN
    logic [BUZZ_DIV_W-1:0] div_q;
    logic                  buzz_q;

    // Buzzer divider runs only while blocked in transit; toggles on wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            buzz_q <= 1'b0;
        end else if ((state_q == TRANSIT) && !OK2Move) begin
            div_q <= div_q + BUZZ_DIV_W'(1);
            if (div_q == '1) begin
                buzz_q <= !buzz_q;
            end
        end else begin
            div_q  <= '0;
            buzz_q <= 1'b0;
        end
    end

    assign buzz_en = buzz_q;
`else
    // Buzzer absent: output tied low, divider width still elaborated
    assign buzz_en = |{BUZZ_DIV_W{1'b0}};
`endif

endmodule

// File: tb/tb_station_ctrl.sv
// Self-checking bench for station_ctrl: directed scenarios plus random
// command/barcode traffic against a cycle-level behavioural model.
module tb_station_ctrl;

    localparam int unsigned TMO_W      = 8;
    localparam int unsigned BUZZ_DIV_W = 3;
    localparam int          TMO_LIMIT  = (1 << TMO_W) - 1;
    localparam int          WAIT_LIM   = 60;
    localparam logic [1:0]  OP_GO      = 2'b01;
    localparam logic [1:0]  OP_STOP    = 2'b00;
    localparam int          M_IDLE     = 0;
    localparam int          M_MOVE     = 1;
    localparam int          M_FAULT    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cmd = '0;
    logic       cmd_rdy = 1'b0;
    logic       clr_cmd_rdy;
    logic [7:0] ID = '0;
    logic       ID_vld = 1'b0;
    logic       clr_ID_vld;
    logic       OK2Move = 1'b1;
    logic       go;
    logic       in_transit;
    logic       timeout;
    logic [3:0] stn_cnt;
    logic       buzz_en;

    station_ctrl #(
        .TMO_W      (TMO_W),
        .BUZZ_DIV_W (BUZZ_DIV_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .ID          (ID),
        .ID_vld      (ID_vld),
        .clr_ID_vld  (clr_ID_vld),
        .OK2Move     (OK2Move),
        .go          (go),
        .in_transit  (in_transit),
        .timeout     (timeout),
        .stn_cnt     (stn_cnt),
        .buzz_en     (buzz_en)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_id_pulse = 0;
    int cyc = 0;
    bit cmd_hold = 0;
    bit cmd_drop = 0;
    bit id_drop = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       ccr;
        logic       cid;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int         m_st = M_IDLE;
    logic [5:0] m_dest = '0;
    int         m_cnt = 0;
    int         m_wd = 0;
    int         m_obs = 0;
    bit         m_go = 0, m_it = 0, m_to = 0, m_ccr = 0, m_cid = 0, m_buzz = 0;

    task automatic model_reset();
        m_st = M_IDLE; m_dest = '0; m_cnt = 0; m_wd = 0; m_obs = 0;
        m_go = 0; m_it = 0; m_to = 0; m_ccr = 0; m_cid = 0; m_buzz = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit         take_c, take_i;
        logic [1:0] op;
        exp_t       e;
        take_c = cmd_rdy && !m_ccr;
        take_i = ID_vld && !m_cid;
        op     = cmd[7:6];
        if (m_st == M_MOVE && !OK2Move) m_obs++;
        else m_obs = 0;
        case (m_st)
            M_IDLE: begin
                m_go = 0;
                if (take_c && op == OP_GO) begin
                    m_dest = cmd[5:0]; m_cnt = 0; m_wd = 0; m_it = 1; m_st = M_MOVE;
                end
            end
            M_MOVE: begin
                m_go = OK2Move;
                if (take_i) begin
                    if (m_cnt < 15) m_cnt++;
                    m_wd = 0;
                end else if (OK2Move) begin
                    m_wd++;
                end
                if (take_c && op == OP_STOP) begin
                    m_it = 0; m_go = 0; m_st = M_IDLE;
                end else if (m_wd >= TMO_LIMIT) begin
                    m_to = 1; m_it = 0; m_go = 0; m_st = M_FAULT;
                end else if (take_c && op == OP_GO) begin
                    m_dest = cmd[5:0]; m_cnt = 0;
                end else if (take_i && ID[5:0] == m_dest) begin
                    m_it = 0; m_go = 0; m_st = M_IDLE;
                end
            end
            default: begin
                m_go = 0;
                if (take_c && op == OP_STOP) begin
                    m_to = 0; m_st = M_IDLE;
                end
            end
        endcase
        m_ccr = take_c;
        m_cid = take_i;
`ifdef OBSTACLE_BUZZ_EN
        m_buzz = ((m_obs >> BUZZ_DIV_W) & 1) != 0;
`else
        m_buzz = 0;
`endif
        if (take_c || take_i) begin
            e.ccr = take_c;
            e.cid = take_i;
            e.cnt = 4'(m_cnt);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("go", go, m_go);
            check("in_transit", in_transit, m_it);
            check("timeout", timeout, m_to);
            check("stn_cnt", stn_cnt, m_cnt);
            check("buzz_en", buzz_en, m_buzz);
            if (clr_ID_vld) n_id_pulse++;
            if (clr_cmd_rdy || clr_ID_vld) begin
                if (exp_q.size() == 0) begin
                    check("spurious_clr", {clr_cmd_rdy, clr_ID_vld}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("clr_cmd_rdy", clr_cmd_rdy, e.ccr);
                    check("clr_ID_vld", clr_ID_vld, e.cid);
                    check("stn_cnt_at_clr", stn_cnt, e.cnt);
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("missing_clr", {clr_cmd_rdy, clr_ID_vld}, {e.ccr, e.cid});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Sources hold rdy through the cycle after the clear, then drop it
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!cmd_hold) begin
            if (cmd_drop) begin
                cmd_rdy = 0; cmd_drop = 0;
            end else if (cmd_rdy && clr_cmd_rdy) begin
                cmd_drop = 1;
            end
        end
        if (id_drop) begin
            ID_vld = 0; id_drop = 0;
        end else if (ID_vld && clr_ID_vld) begin
            id_drop = 1;
        end
    endtask

    task automatic put_cmd(input logic [1:0] op, input logic [5:0] stn);
        int n = 0;
        while ((cmd_rdy || cmd_drop) && n < WAIT_LIM) begin tick(); n++; end
        check("cmd_channel_free", int'(n < WAIT_LIM), 1);
        cmd = {op, stn};
        cmd_rdy = 1;
    endtask

    task automatic put_id(input logic [7:0] v);
        int n = 0;
        while ((ID_vld || id_drop) && n < WAIT_LIM) begin tick(); n++; end
        check("id_channel_free", int'(n < WAIT_LIM), 1);
        ID = v;
        ID_vld = 1;
    endtask

    task automatic wait_cmd_done();
        int n = 0;
        while (cmd_rdy && n < WAIT_LIM) begin tick(); n++; end
        check("cmd_consumed", int'(cmd_rdy), 0);
    endtask

    task automatic wait_id_done();
        int n = 0;
        while (ID_vld && n < WAIT_LIM) begin tick(); n++; end
        check("id_consumed", int'(ID_vld), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL sim_time_bound: got %0d cycles expected completion", cyc);
        $fatal(1, "simulation time bound expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int p0, start, stop;
        logic [1:0] op;
        int r;

        repeat (3) tick();
        rst_n = 1;
        @(posedge clk); #1;
        check("rst_go", go, 0);
        check("rst_in_transit", in_transit, 0);
        check("rst_timeout", timeout, 0);
        check("rst_stn_cnt", stn_cnt, 0);
        check("rst_clrs", {clr_cmd_rdy, clr_ID_vld}, 0);
        check("rst_buzz", buzz_en, 0);

        // Arrival after two stations
        tick();
        put_cmd(OP_GO, 6'h05);
        wait_cmd_done();
        p0 = n_id_pulse;
        put_id(8'h03);
        wait_id_done();
        put_id(8'hC5);
        wait_id_done();
        tick(); tick();
        check("arrive_id_pulses", n_id_pulse - p0, 2);
        check("arrive_in_transit", in_transit, 0);
        check("arrive_go", go, 0);
        check("arrive_stn_cnt", stn_cnt, 2);

        // Obstacle: go follows OK2Move one cycle later, watchdog paused
        put_cmd(OP_GO, 6'h0A);
        wait_cmd_done();
        tick(); tick();
        check("move_go", go, 1);
        OK2Move = 0;
        @(posedge clk); #1;
        check("obstacle_go_latency", go, 0);
        repeat (100) tick();
        check("obstacle_timeout", timeout, 0);
        check("obstacle_in_transit", in_transit, 1);
        OK2Move = 1;
        put_cmd(OP_STOP, 6'h00);
        wait_cmd_done();
        tick();
        check("stop_in_transit", in_transit, 0);

        // Watchdog expiry after 2^TMO_W-1 moving cycles
        put_cmd(OP_GO, 6'h3F);
        start = -1; stop = -1;
        for (int i = 0; i < 400 && stop < 0; i++) begin
            tick();
            if (clr_cmd_rdy && start < 0) start = cyc;
            if (timeout) stop = cyc;
        end
        check("wdog_cycles", stop - start, TMO_LIMIT);
        check("fault_go", go, 0);
        check("fault_in_transit", in_transit, 0);
        put_cmd(OP_GO, 6'h01);
        wait_cmd_done();
        tick();
        check("fault_go_ignored", timeout, 1);
        put_cmd(OP_STOP, 6'h00);
        wait_cmd_done();
        tick();
        check("fault_stop_clears", timeout, 0);

        // Station read and STOP together at the destination
        put_cmd(OP_GO, 6'h0A);
        wait_cmd_done();
        tick();
        put_cmd(OP_STOP, 6'h00);
        put_id(8'h0A);
        @(posedge clk); #1;
        check("both_clr_pulses", {clr_cmd_rdy, clr_ID_vld}, 3);
        tick(); tick();
        check("both_in_transit", in_transit, 0);
        check("both_stn_cnt", stn_cnt, 1);

        // GO together with a matching read: retarget wins, count restarts
        put_cmd(OP_GO, 6'h0A);
        wait_cmd_done();
        tick();
        put_cmd(OP_GO, 6'h0B);
        put_id(8'h0A);
        tick(); tick(); tick();
        check("retarget_in_transit", in_transit, 1);
        check("retarget_stn_cnt", stn_cnt, 0);
        put_cmd(OP_STOP, 6'h00);
        wait_cmd_done();
        tick();

        // cmd_rdy held three cycles: consumed, ignored, consumed again
        cmd_hold = 1;
        cmd = {OP_GO, 6'h07};
        cmd_rdy = 1;
        @(posedge clk); #1;
        check("hold_clr_n1", clr_cmd_rdy, 1);
        tick();
        @(posedge clk); #1;
        check("hold_clr_n2", clr_cmd_rdy, 0);
        tick();
        @(posedge clk); #1;
        check("hold_clr_n3", clr_cmd_rdy, 1);
        tick();
        cmd_rdy = 0;
        cmd_hold = 0;
        repeat (3) tick();
        check("hold_in_transit", in_transit, 1);
        check("hold_go", go, 1);

        // Asynchronous reset mid-transit
        #2;
        rst_n = 0;
        #1;
        check("areset_go", go, 0);
        check("areset_in_transit", in_transit, 0);
        check("areset_timeout", timeout, 0);
        check("areset_stn_cnt", stn_cnt, 0);
        check("areset_clrs", {clr_cmd_rdy, clr_ID_vld}, 0);
        cmd_rdy = 0; ID_vld = 0; cmd_drop = 0; id_drop = 0;
        tick(); tick();
        rst_n = 1;

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            tick();
            OK2Move = ($urandom_range(0, 9) != 0);
            if (!cmd_rdy && !cmd_drop && $urandom_range(0, 5) == 0) begin
                r = int'($urandom_range(0, 9));
                if (r < 5) op = OP_GO;
                else if (r < 8) op = OP_STOP;
                else op = 2'($urandom_range(2, 3));
                cmd = {op, 6'($urandom_range(0, 7))};
                cmd_rdy = 1;
            end
            if (!ID_vld && !id_drop && $urandom_range(0, 2) == 0) begin
                ID = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
                ID_vld = 1;
            end
        end
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
